ws_key_scanner: RTL and testbench

// Keyboard matrix scan controller for the HP67 Woodstock core. It sequences the

---
 rtl/ws_key_scanner.sv | 100 ++++++++++
 tb/tb_ws_key_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ws_key_scanner.sv
// ws_key_scanner: HP67 Woodstock split-keyboard column scanner with row sync, debounce and valid/ack key handoff
module ws_key_scanner #(
  parameter int SETTLE   = 3,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       scan_en_in,
  input  logic [3:0] rowsl_in,
  input  logic [3:0] rowsr_in,
  output logic [5:0] col_l_oe_o,
  output logic [4:0] col_r_oe_o,
  output logic [5:0] key_code_o,
  output logic       key_valid_o,
  input  logic       key_ack_in,
  output logic       key_down_o,
  output logic       multi_key_o,
  output logic       overrun_o
);
  localparam int SW = $clog2(SETTLE);
  localparam logic [5:0] NONE = 6'h3f;
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, NEXT} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] settle;
  logic [2:0] step;
  logic [3:0] sync_l1, sync_l2, sync_r1, sync_r2, act_l, act_r, hits, stable, stable_nxt;
  logic [1:0] hit_cnt, row_l, row_r;
  logic [5:0] rec, prev_cand, cand, first_code;
  logic active, scan_end, accept, release_k, ack_hit, dropped, wrap;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = scan_en_in ? DRIVE : IDLE;
      DRIVE:   state_nxt = (settle == SW'(SETTLE - 1)) ? SAMPLE : DRIVE;
      SAMPLE:  state_nxt = NEXT;
      default: state_nxt = scan_en_in ? DRIVE : IDLE;
    endcase
  end
  assign active      = state == DRIVE || state == SAMPLE;
  assign col_l_oe_o  = active ? 6'b1 << step : '0;
  assign col_r_oe_o  = (active && step != 3'd5) ? 5'b1 << step : '0;
  assign act_l       = ~sync_l2;
  assign act_r       = step != 3'd5 ? ~sync_r2 : '0;
  assign hits        = 4'($countones(act_l)) + 4'($countones(act_r));
  assign row_l       = act_l[0] ? 2'd0 : act_l[1] ? 2'd1 : act_l[2] ? 2'd2 : 2'd3;
  assign row_r       = act_r[0] ? 2'd0 : act_r[1] ? 2'd1 : act_r[2] ? 2'd2 : 2'd3;
  assign first_code  = |act_l ? {1'b0, step, row_l} : {1'b1, step, row_r};
  // a multi-key scan is treated as no key at all (no rollover)
  assign cand        = hit_cnt == 2'd1 ? rec : NONE;
  assign stable_nxt  = cand != prev_cand ? 4'd1 : stable == 4'hf ? stable : stable + 4'd1;
  assign wrap        = step == 3'd5 || !scan_en_in;
  assign scan_end    = state == NEXT && step == 3'd5;
  assign accept      = scan_end && stable_nxt >= 4'(DEBOUNCE) && cand != NONE && !key_down_o;
  assign release_k   = scan_end && stable_nxt >= 4'(DEBOUNCE) && cand == NONE;
  assign ack_hit     = key_ack_in && key_valid_o;
  assign dropped     = accept && key_valid_o && !key_ack_in;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      settle      <= '0;
      step        <= '0;
      {sync_l2, sync_l1, sync_r2, sync_r1} <= '1;
      hit_cnt     <= '0;
      rec         <= '0;
      prev_cand   <= NONE;
      stable      <= '0;
      key_code_o  <= '0;
      key_valid_o <= 1'b0;
      key_down_o  <= 1'b0;
      multi_key_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      {sync_l2, sync_l1} <= {sync_l1, rowsl_in};
      {sync_r2, sync_r1} <= {sync_r1, rowsr_in};
      settle <= state == DRIVE ? settle + SW'(1) : '0;
      if (state == SAMPLE) begin
        hit_cnt <= ({2'b0, hit_cnt} + hits >= 4'd2) ? 2'd2 : hit_cnt + hits[1:0];
        if (hit_cnt == 2'd0 && hits != 4'd0) rec <= first_code;
      end
      // an aborted partial scan is discarded along with its hit count
      if (state == NEXT) begin
        step <= wrap ? 3'd0 : step + 3'd1;
        if (wrap) hit_cnt <= '0;
      end
      if (scan_end) begin
        prev_cand   <= cand;
        stable      <= stable_nxt;
        multi_key_o <= hit_cnt == 2'd2;
      end
      if (accept) key_down_o <= 1'b1;
      else if (release_k) key_down_o <= 1'b0;
      if (accept && (!key_valid_o || key_ack_in)) begin
        key_code_o  <= cand;
        key_valid_o <= 1'b1;
      end else if (ack_hit) key_valid_o <= 1'b0;
      overrun_o <= dropped | (overrun_o & ~ack_hit);
    end
  end
endmodule

// File: tb/tb_ws_key_scanner.sv
// tb_ws_key_scanner: directed keyboard-model bench for the Woodstock key scanner
module tb_ws_key_scanner;
  logic clk = 1'b0, rst_n = 1'b0, scan_en = 1'b0, ack = 1'b0;
  logic [3:0] rowsl, rowsr;
  logic [5:0] col_l, code;
  logic [4:0] col_r;
  logic valid, down, multi, overrun;
  logic [3:0][5:0] kl = '0;
  logic [3:0][4:0] kr = '0;
  int n_cmp = 0, n_bad = 0, n;
  ws_key_scanner dut (
    .clk_in(clk), .rst_n_in(rst_n), .scan_en_in(scan_en),
    .rowsl_in(rowsl), .rowsr_in(rowsr),
    .col_l_oe_o(col_l), .col_r_oe_o(col_r),
    .key_code_o(code), .key_valid_o(valid), .key_ack_in(ack),
    .key_down_o(down), .multi_key_o(multi), .overrun_o(overrun)
  );
  always #5 clk = ~clk;
  // keyboard matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    rowsl = '1;
    rowsr = '1;
    for (int r = 0; r < 4; r++) begin
      rowsl[r] = ~|(col_l & kl[r]);
      rowsr[r] = ~|(col_r & kr[r]);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_l(input logic [5:0] v);
    int k = 0;
    while (col_l != v && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_bad++;
      $display("FAIL wait_col: got %0h expected %0h", col_l, v);
    end
  endtask
  task automatic wait_drive();
    int k = 0;
    while (col_l == 6'h00 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_bad++;
      $display("FAIL wait_drive: got %0h expected nonzero", col_l);
    end
  endtask
  // returns just after the end-of-scan edge; optional ack lands exactly on that edge
  task automatic scan_end(input logic a);
    wait_l(6'h20);
    wait_l(6'h00);
    ack = a;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask
  task automatic scans(input int k);
    for (int i = 0; i < k; i++) scan_end(1'b0);
  endtask
  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask
  initial begin
    scan_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {col_l, col_r, code, valid, down, multi, overrun}, 0);
    rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      wait_drive();
      n = 0;
      while (col_l != 6'h00 && n < 20) begin
        chk($sformatf("walk_l s%0d", s), col_l, 6'b1 << s);
        chk($sformatf("walk_r s%0d", s), col_r, s < 5 ? 5'b1 << s : 5'h00);
        n++;
        @(negedge clk);
      end
      chk($sformatf("drive_len s%0d", s), n, 4);
      chk($sformatf("gap_r s%0d", s), col_r, 0);
      @(negedge clk);
      chk($sformatf("gap_next s%0d", s), col_l, 6'b1 << ((s + 1) % 6));
    end
    scan_end(1'b0);
    kl[1][2] = 1'b1;
    scans(2);
    chk("left_2scans_valid", valid, 0);
    scan_end(1'b0);
    chk("left_valid", valid, 1);
    chk("left_code", code, 6'h09);
    chk("left_down", down, 1);
    chk("left_multi", multi, 0);
    do_ack();
    chk("left_ack_valid", valid, 0);
    chk("left_ack_code_held", code, 6'h09);
    scans(3);
    chk("left_no_repeat", valid, 0);
    chk("left_held_down", down, 1);
    kl[1][2] = 1'b0;
    scans(2);
    chk("left_rel_2", down, 1);
    scan_end(1'b0);
    chk("left_rel_3", down, 0);
    kr[3][4] = 1'b1;
    scans(2);
    chk("bounce_a", valid, 0);
    kr[3][4] = 1'b0;
    scan_end(1'b0);
    kr[3][4] = 1'b1;
    scans(2);
    chk("bounce_b", valid, 0);
    scan_end(1'b0);
    chk("right_valid", valid, 1);
    chk("right_code", code, 6'h33);
    kr[3][4] = 1'b0;
    scans(3);
    chk("right_rel_down", down, 0);
    do_ack();
    kl[0][0] = 1'b1;
    kr[2][1] = 1'b1;
    scan_end(1'b0);
    chk("two_multi", multi, 1);
    chk("two_valid", valid, 0);
    scans(2);
    chk("two_valid_3", valid, 0);
    chk("two_down", down, 0);
    kr[2][1] = 1'b0;
    scans(2);
    chk("one_left_2", valid, 0);
    scan_end(1'b0);
    chk("one_left_valid", valid, 1);
    chk("one_left_code", code, 6'h00);
    chk("one_left_multi", multi, 0);
    kl[0][0] = 1'b0;
    scans(3);
    do_ack();
    kl[1][2] = 1'b1;
    scans(3);
    chk("ovr_first_valid", valid, 1);
    kl[1][2] = 1'b0;
    scans(3);
    kr[3][4] = 1'b1;
    scans(3);
    chk("ovr_flag", overrun, 1);
    chk("ovr_code_kept", code, 6'h09);
    chk("ovr_down", down, 1);
    do_ack();
    chk("ovr_ack_valid", valid, 0);
    chk("ovr_ack_flag", overrun, 0);
    kr[3][4] = 1'b0;
    scans(3);
    kl[1][2] = 1'b1;
    scans(3);
    kl[1][2] = 1'b0;
    scans(3);
    kr[3][4] = 1'b1;
    scans(2);
    scan_end(1'b1);
    chk("simul_valid", valid, 1);
    chk("simul_code", code, 6'h33);
    chk("simul_overrun", overrun, 0);
    wait_l(6'h08);
    scan_en = 1'b0;
    @(negedge clk);
    chk("abort_step_finishes", col_l, 6'h08);
    repeat (10) @(negedge clk);
    chk("abort_idle_cols", {col_l, col_r}, 0);
    chk("abort_state_kept", {valid, code, down}, {1'b1, 6'h33, 1'b1});
    scan_en = 1'b1;
    wait_drive();
    chk("resume_step0", col_l, 6'h01);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cols", {col_l, col_r}, 0);
    chk("async_rst_key", {valid, code, down, overrun}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
